// File: rtl/apu_pkg.sv
// Shared APU constants: frame sequencer step thresholds and mode encoding.
// Imported by the frame counter and downstream channel units.
package apu_pkg;

  localparam int unsigned FC_STEP1   = 7457;
  localparam int unsigned FC_STEP2   = 14913;
  localparam int unsigned FC_STEP3   = 22371;
  localparam int unsigned FC_STEP4_4 = 29829;
  localparam int unsigned FC_STEP4_5 = 37281;

  localparam logic FC_MODE4 = 1'b0;
  localparam logic FC_MODE5 = 1'b1;

endpackage

// File: rtl/apu_frame_counter.sv
// APU frame sequencer: quarter/half-frame pulses, $4017 delayed reset, frame IRQ.
// Define FRAME_IRQ_EN to build the IRQ flag, inhibit and $4015 read clear.
module apu_frame_counter
  import apu_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int WR_DELAY = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_4017,
  input  logic [7:0] wdata,
  input  logic       rd_4015,
  output logic       qframe,
  output logic       hframe,
  output logic       irq,
  output logic       mode
);

  // dly counts the edges left before the reset edge (the edge seeing 1)
  localparam logic [2:0] DLY_LD = 3'(WR_DELAY - 1);
  localparam logic       FIRE_WR = (WR_DELAY == 1);

  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] wrap_v;
  logic             mode_q, mode_d;
  logic             inh_q, inh_d;
  logic [2:0]       dly_q, dly_d;
  logic             qf_q, qf_d;
  logic             hf_q, hf_d;
  logic             fire;
  logic             irq_set;

  always_comb begin
    mode_d = mode_q;
    inh_d  = inh_q;
    dly_d  = dly_q;
    fire   = 1'b0;
    if (wr_4017) begin
      mode_d = wdata[7];
      inh_d  = wdata[6];
      dly_d  = DLY_LD;
      fire   = FIRE_WR;
    end else if (dly_q != 3'd0) begin
      dly_d = dly_q - 3'd1;
      fire  = (dly_q == 3'd1);
    end
  end

  always_comb begin
    wrap_v  = (mode_q == FC_MODE5) ? CNT_W'(FC_STEP4_5)
                                   : CNT_W'(FC_STEP4_4);
    cyc_d   = cyc_q + 1'b1;
    qf_d    = 1'b0;
    hf_d    = 1'b0;
    irq_set = 1'b0;
    if (fire) begin
      cyc_d = '0;
      qf_d  = (mode_d == FC_MODE5);
      hf_d  = (mode_d == FC_MODE5);
    end else begin
      unique case (1'b1)
        (cyc_q == wrap_v): begin
          cyc_d   = '0;
          qf_d    = 1'b1;
          hf_d    = 1'b1;
          irq_set = (mode_q == FC_MODE4) && !inh_q;
        end
        (cyc_q == CNT_W'(FC_STEP2)): begin
          qf_d = 1'b1;
          hf_d = 1'b1;
        end
        (cyc_q == CNT_W'(FC_STEP1)),
        (cyc_q == CNT_W'(FC_STEP3)): begin
          qf_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q  <= '0;
      mode_q <= FC_MODE4;
      inh_q  <= 1'b0;
      dly_q  <= 3'd0;
      qf_q   <= 1'b0;
      hf_q   <= 1'b0;
    end else begin
      cyc_q  <= cyc_d;
      mode_q <= mode_d;
      inh_q  <= inh_d;
      dly_q  <= dly_d;
      qf_q   <= qf_d;
      hf_q   <= hf_d;
    end
  end

`ifdef FRAME_IRQ_EN
  logic irq_q, irq_d;

  // a set on the same edge as any clear wins
  always_comb begin
    irq_d = irq_q;
    if (rd_4015 || (wr_4017 && wdata[6])) irq_d = 1'b0;
    if (irq_set) irq_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end

  assign irq = irq_q;
`else
  logic unused_irq;
  assign unused_irq = ^{inh_q, rd_4015, irq_set};
  assign irq = 1'b0;
`endif

  logic unused_wdata;
  assign unused_wdata = ^wdata[5:0];

  assign qframe = qf_q;
  assign hframe = hf_q;
  assign mode   = mode_q;

endmodule

// File: tb/tb_apu_frame_counter.sv
// Directed bench for apu_frame_counter: sequencing, write reset, IRQ, async reset.
// IRQ expectations follow FRAME_IRQ_EN.
module tb_apu_frame_counter;

`ifdef FRAME_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       wr_4017;
  logic [7:0] wdata;
  logic       rd_4015;
  logic       qframe;
  logic       hframe;
  logic       irq;
  logic       mode;

  int cyc;
  int nq;
  int nh;
  int checks;
  int fails;

  apu_frame_counter #(
    .CNT_W(16),
    .WR_DELAY(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_4017(wr_4017),
    .wdata(wdata),
    .rd_4015(rd_4015),
    .qframe(qframe),
    .hframe(hframe),
    .irq(irq),
    .mode(mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (qframe) nq++;
    if (hframe) nh++;
  endtask

  task automatic run_to(input int t);
    nq = 0;
    nh = 0;
    while (cyc < t) tick();
  endtask

  task automatic wr(input logic [7:0] d);
    wr_4017 = 1'b1;
    wdata   = d;
    tick();
    wr_4017 = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  initial begin
    checks  = 0;
    fails   = 0;
    cyc     = 0;
    nq      = 0;
    nh      = 0;
    rst_n   = 1'b0;
    wr_4017 = 1'b0;
    wdata   = 8'h00;
    rd_4015 = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_q", qframe, 0);
    chk("rst_h", hframe, 0);
    chk("rst_irq", irq, 0);
    chk("rst_mode", mode, 0);
    rst_n = 1'b1;
    cyc   = 0;

    // 4-step sequence from reset
    run_to(7457);
    chk("m4_pre_q1", nq, 0);
    tick();
    chk("m4_q1", qframe, 1);
    chk("m4_q1_h", hframe, 0);
    run_to(14914);
    chk("m4_q2", qframe, 1);
    chk("m4_h2", hframe, 1);
    chk("m4_cnt2", nq, 1);
    run_to(22372);
    chk("m4_q3", qframe, 1);
    chk("m4_q3_h", hframe, 0);
    run_to(29829);
    chk("m4_pre_wrap", nq, 0);
    chk("m4_pre_irq", irq, 0);

    // read strobe on the IRQ set edge: set wins
    rd_4015 = 1'b1;
    tick();
    rd_4015 = 1'b0;
    chk("m4_q4", qframe, 1);
    chk("m4_h4", hframe, 1);
    chk("irq_set_wins", irq, IRQ_EN);

    // inhibit write clears irq on its edge
    wr(8'h40);
    chk("wr_inh_clr", irq, 0);
    chk("wr_inh_mode", mode, 0);
    run_to(29833);
    chk("m4_rst_nopulse", nq, 0);

    // write at cyc=7455: reset beats the 7457 threshold
    run_to(37288);
    chk("pre_7455", nq, 0);
    wr(8'h40);
    run_to(37291);
    chk("no_q_7457", nq, 0);
    chk("no_q_7457_lvl", qframe, 0);

    // second write one cycle after first restarts the delay
    wr(8'h80);
    wr(8'h80);
    run_to(37294);
    chk("rewr_early", nq, 0);
    chk("rewr_mode", mode, 1);
    tick();
    chk("m5_imm_q", qframe, 1);
    chk("m5_imm_h", hframe, 1);

    // 5-step sequence
    run_to(44752);
    chk("m5_pre_q1", nq, 0);
    tick();
    chk("m5_q1", qframe, 1);
    run_to(52209);
    chk("m5_q2", qframe, 1);
    chk("m5_h2", hframe, 1);
    run_to(59667);
    chk("m5_q3", qframe, 1);
    chk("m5_q3_h", hframe, 0);
    run_to(67125);
    chk("m5_no_29829", nq, 0);
    chk("m5_no_irq_a", irq, 0);
    run_to(74577);
    chk("m5_wrap_q", qframe, 1);
    chk("m5_wrap_h", hframe, 1);
    chk("m5_wrap_cnt", nh, 1);
    chk("m5_no_irq_b", irq, 0);

    // async reset with a write pending
    wr(8'h80);
    rst_n = 1'b0;
    #1;
    chk("arst_q", qframe, 0);
    chk("arst_h", hframe, 0);
    chk("arst_irq", irq, 0);
    chk("arst_mode", mode, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    run_to(7457);
    chk("arst_no_q", nq, 0);
    chk("arst_no_h", nh, 0);
    tick();
    chk("arst_q1", qframe, 1);
    chk("arst_q1_h", hframe, 0);
    chk("arst_q1_mode", mode, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
